pe_mem_client: RTL and testbench

PE_MEM_CLIENT -- requirements
Module: pe_mem_client

---
 rtl/pe_mem_client_pkg.sv | 54 +++++
 rtl/pe_mem_client_word_buffer.sv | 46 ++++
 rtl/pe_mem_client.sv | 241 ++++++++++++++++++++++++
 tb/tb_pe_mem_client.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mem_client_pkg.sv
// -----------------------------------------------------------------------------
// pe_mem_client_pkg -- the shared dataformat package for the PE memory client.
//
// Contents:
//   * bit positions of the 18-bit packet fields
//     (type, source index, destination index, payload)
//   * packet type encodings
//   * FSM state enumeration used by pe_mem_client
//   * address width of the local word buffers
//   * make_pkt helper that assembles a packet from its fields
// -----------------------------------------------------------------------------
package pe_mem_client_pkg;

    // Packet field positions
    localparam int unsigned PKT_W   = 18;
    localparam int unsigned TYPE_HI = 17;
    localparam int unsigned TYPE_LO = 16;
    localparam int unsigned SRC_HI  = 15;
    localparam int unsigned SRC_LO  = 12;
    localparam int unsigned DST_HI  = 11;
    localparam int unsigned DST_LO  = 8;
    localparam int unsigned PAY_HI  = 7;
    localparam int unsigned PAY_LO  = 0;

    // Word-buffer address width (matches the rd_addr port)
    localparam int unsigned BUF_AW  = 3;

    typedef enum logic [1:0] {
        PKT_RESULT  = 2'b00,
        PKT_IFMAP   = 2'b01,
        PKT_FILTER  = 2'b10,
        PKT_ILLEGAL = 2'b11
    } pkt_type_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4,
        R_SEND = 3'd5,
        DONE   = 3'd6
    } state_e;

    function automatic logic [PKT_W-1:0] make_pkt(
        input pkt_type_e  typ,
        input logic [3:0] src,
        input logic [3:0] dst,
        input logic [7:0] payload
    );
        return {typ, src, dst, payload};
    endfunction

endpackage

// File: rtl/pe_mem_client_word_buffer.sv
// -----------------------------------------------------------------------------
// pe_word_buffer -- small register-file word buffer.
//
// Ports:
//   clk    in        clock, rising edge
//   reset  in        asynchronous active-high reset, clears every word
//   we     in        write enable
//   waddr  in  AW    write address (writes beyond DEPTH are ignored)
//   wdata  in  DW    write data
//   raddr  in  AW    combinational read address
//   rdata  out DW    read data; 0 for addresses at or beyond DEPTH
// -----------------------------------------------------------------------------
module pe_word_buffer #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/pe_mem_client.sv
// -----------------------------------------------------------------------------
// pe_mem_client -- processing-element client of a packet-based memory node.
//
// On a start pulse it fetches FILTER_NUM filter words and then IFMAP_NUM ifmap
// words, one request/response pair at a time, into two local word buffers,
// then pulses done. From IDLE it can also forward one PE result to memory as a
// result-write packet.
//
// Ports:
//   clk, reset                        clock; asynchronous active-high reset
//   my_index, mem_index   in WIDTH    own / memory node index
//   start                 in          job request pulse (IDLE only)
//   filter_base, ifmap_base in 8      base word addresses of the job
//   busy, done, err       out         not idle / one-cycle job end / sticky error
//   req_valid/ready/data              request packets to memory
//   rsp_valid/ready/data              response packets from memory
//   res_valid/ready/data              PE result to write back
//   rd_sel, rd_addr, rd_data          combinational buffer read (0 filter, 1 ifmap)
// -----------------------------------------------------------------------------
module pe_mem_client
    import pe_mem_client_pkg::*;
#(
    parameter int unsigned WIDTH            = 4,
    parameter int unsigned VALID_DATA_WIDTH = 8,
    parameter int unsigned DATA_WIDTH       = 18,
    parameter int unsigned FILTER_NUM       = 5,
    parameter int unsigned IFMAP_NUM        = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            my_index,
    input  logic [WIDTH-1:0]            mem_index,
    input  logic                        start,
    input  logic [VALID_DATA_WIDTH-1:0] filter_base,
    input  logic [VALID_DATA_WIDTH-1:0] ifmap_base,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [DATA_WIDTH-1:0]       req_data,
    input  logic                        rsp_valid,
    output logic                        rsp_ready,
    input  logic [DATA_WIDTH-1:0]       rsp_data,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [VALID_DATA_WIDTH-1:0] res_data,
    input  logic                        rd_sel,
    input  logic [BUF_AW-1:0]           rd_addr,
    output logic [VALID_DATA_WIDTH-1:0] rd_data
);

    localparam logic [BUF_AW-1:0] F_LAST = BUF_AW'(FILTER_NUM - 1);
    localparam logic [BUF_AW-1:0] I_LAST = BUF_AW'(IFMAP_NUM - 1);

    state_e                      state_q, state_d;
    logic [BUF_AW-1:0]           cnt_q, cnt_d;
    logic [VALID_DATA_WIDTH-1:0] fbase_q, fbase_d;
    logic [VALID_DATA_WIDTH-1:0] ibase_q, ibase_d;
    logic [VALID_DATA_WIDTH-1:0] res_q, res_d;
    logic                        err_q, err_d;

    logic                        fbuf_we, ibuf_we;
    logic [VALID_DATA_WIDTH-1:0] fbuf_rdata, ibuf_rdata;
    logic [VALID_DATA_WIDTH-1:0] f_addr, i_addr;

    logic [1:0]                  rsp_type;
    logic [WIDTH-1:0]            rsp_dst;
    logic [VALID_DATA_WIDTH-1:0] rsp_pay;
    logic                        rsp_fire;
    logic                        unused_rsp_src;

    assign rsp_type       = rsp_data[TYPE_HI:TYPE_LO];
    assign rsp_dst        = rsp_data[DST_HI:DST_LO];
    assign rsp_pay        = rsp_data[PAY_HI:PAY_LO];
    // The source field of a response carries no information for this client.
    assign unused_rsp_src = ^rsp_data[SRC_HI:SRC_LO];

    assign rsp_fire = rsp_valid && rsp_ready;

    // Word addresses wrap modulo 2^VALID_DATA_WIDTH.
    assign f_addr = fbase_q + VALID_DATA_WIDTH'(cnt_q);
    assign i_addr = ibase_q + VALID_DATA_WIDTH'(cnt_q);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fbase_q <= '0;
            ibase_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fbase_q <= fbase_d;
            ibase_q <= ibase_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fbase_d = fbase_q;
        ibase_d = ibase_q;
        res_d   = res_q;
        err_d   = err_q;
        fbuf_we = 1'b0;
        ibuf_we = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    fbase_d = filter_base;
                    ibase_d = ifmap_base;
                    cnt_d   = '0;
                    state_d = F_REQ;
                end else if (res_valid) begin
                    res_d   = res_data;
                    state_d = R_SEND;
                end
            end
            F_REQ: begin
                if (req_ready) state_d = F_WAIT;
            end
            F_WAIT: begin
                if (rsp_fire) begin
                    // A mismatched packet is still consumed so memory is never stalled.
                    if (rsp_type == PKT_FILTER && rsp_dst == my_index) begin
                        fbuf_we = 1'b1;
                        if (cnt_q == F_LAST) begin
                            cnt_d   = '0;
                            state_d = I_REQ;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = F_REQ;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            I_REQ: begin
                if (req_ready) state_d = I_WAIT;
            end
            I_WAIT: begin
                if (rsp_fire) begin
                    if (rsp_type == PKT_IFMAP && rsp_dst == my_index) begin
                        ibuf_we = 1'b1;
                        if (cnt_q == I_LAST) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = I_REQ;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            R_SEND: begin
                if (req_ready) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        err       = err_q;
        req_valid = 1'b0;
        req_data  = '0;
        rsp_ready = (state_q == F_WAIT) || (state_q == I_WAIT);
        // res_ready is combinational on res_valid; gate with reset so it is
        // low for the whole reset window even though IDLE is already forced.
        res_ready = (state_q == IDLE) && res_valid && !start && !reset;

        unique case (state_q)
            F_REQ: begin
                req_valid = 1'b1;
                req_data  = {PKT_FILTER, mem_index, my_index, f_addr};
            end
            I_REQ: begin
                req_valid = 1'b1;
                req_data  = {PKT_IFMAP, mem_index, my_index, i_addr};
            end
            R_SEND: begin
                req_valid = 1'b1;
                req_data  = {PKT_RESULT, mem_index, my_index, res_q};
            end
            default: begin
                req_valid = 1'b0;
                req_data  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------- buffers
    pe_word_buffer #(
        .DEPTH (FILTER_NUM),
        .DW    (VALID_DATA_WIDTH),
        .AW    (BUF_AW)
    ) u_filter_buf (
        .clk   (clk),
        .reset (reset),
        .we    (fbuf_we),
        .waddr (cnt_q),
        .wdata (rsp_pay),
        .raddr (rd_addr),
        .rdata (fbuf_rdata)
    );

    pe_word_buffer #(
        .DEPTH (IFMAP_NUM),
        .DW    (VALID_DATA_WIDTH),
        .AW    (BUF_AW)
    ) u_ifmap_buf (
        .clk   (clk),
        .reset (reset),
        .we    (ibuf_we),
        .waddr (cnt_q),
        .wdata (rsp_pay),
        .raddr (rd_addr),
        .rdata (ibuf_rdata)
    );

    assign rd_data = rd_sel ? ibuf_rdata : fbuf_rdata;

endmodule

// File: tb/tb_pe_mem_client.sv
// -----------------------------------------------------------------------------
// tb_pe_mem_client -- directed bench for pe_mem_client.
// Expected request packets are queued when a job is launched and popped as the
// DUT presents each request; a small memory model answers with payload addr+3.
// -----------------------------------------------------------------------------
module tb_pe_mem_client;

    localparam logic [3:0] MY  = 4'h3;
    localparam logic [3:0] MEM = 4'hA;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  my_index, mem_index;
    logic        start;
    logic [7:0]  filter_base, ifmap_base;
    logic        busy, done, err;
    logic        req_valid, req_ready;
    logic [17:0] req_data;
    logic        rsp_valid, rsp_ready;
    logic [17:0] rsp_data;
    logic        res_valid, res_ready;
    logic [7:0]  res_data;
    logic        rd_sel;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [17:0] exp_req_q [$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    pe_mem_client #(
        .WIDTH            (4),
        .VALID_DATA_WIDTH (8),
        .DATA_WIDTH       (18),
        .FILTER_NUM       (5),
        .IFMAP_NUM        (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .my_index    (my_index),
        .mem_index   (mem_index),
        .start       (start),
        .filter_base (filter_base),
        .ifmap_base  (ifmap_base),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    function automatic logic [17:0] pkt(input logic [1:0] t, input logic [3:0] s,
                                        input logic [3:0] d, input logic [7:0] p);
        return {t, s, d, p};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, compare it with the scoreboard head, hold
    // req_ready low for 'hold' cycles, then accept it.
    task automatic serve_req(input int hold, input bit fetch);
        logic [17:0] e;
        int n;
        n = 0;
        while (req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_valid_timeout", {31'b0, req_valid}, 32'd1);
        if (exp_req_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_req_q.pop_front();
        end
        check("req_data", {14'b0, req_data}, {14'b0, e});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_req_valid", {31'b0, req_valid}, 32'd1);
            check("bp_req_data", {14'b0, req_data}, {14'b0, e});
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("single_outstanding", {31'b0, req_valid}, 32'd0);
        check("rsp_ready_after_req", {31'b0, rsp_ready}, {31'b0, fetch});
    endtask

    task automatic send_rsp(input logic [17:0] p);
        rsp_valid = 1'b1;
        rsp_data  = p;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
    endtask

    task automatic run_job(input logic [7:0] fb, input logic [7:0] ib,
                           input int hold, input bit bad);
        logic [1:0] t;
        logic [7:0] a;
        for (int i = 0; i < 5; i++) exp_req_q.push_back(pkt(2'b10, MEM, MY, 8'(fb + 8'(i))));
        for (int i = 0; i < 7; i++) exp_req_q.push_back(pkt(2'b01, MEM, MY, 8'(ib + 8'(i))));
        filter_base = fb;
        ifmap_base  = ib;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_job", {31'b0, busy}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            t = (k < 5) ? 2'b10 : 2'b01;
            a = (k < 5) ? 8'(fb + 8'(k)) : 8'(ib + 8'(k - 5));
            serve_req((k == 0) ? hold : 0, 1'b1);
            if (k == 0 && bad) begin
                send_rsp(pkt(2'b01, MEM, MY, 8'hEE));
                check("bad_type_err", {31'b0, err}, 32'd1);
                check("bad_type_stay", {31'b0, rsp_ready}, 32'd1);
                check("bad_type_noreq", {31'b0, req_valid}, 32'd0);
                send_rsp(pkt(2'b10, MEM, 4'h5, 8'hDD));
                check("bad_dst_stay", {31'b0, rsp_ready}, 32'd1);
            end
            send_rsp(pkt(t, MEM, MY, 8'(a + 8'd3)));
        end
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_in_done", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_after_job", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_bufs(input logic [7:0] fb, input logic [7:0] ib);
        logic [7:0] e;
        for (int a = 0; a < 8; a++) begin
            rd_sel  = 1'b0;
            rd_addr = 3'(a);
            #1;
            e = (a < 5) ? 8'(fb + 8'(a) + 8'd3) : 8'h00;
            check($sformatf("filter_buf[%0d]", a), {24'b0, rd_data}, {24'b0, e});
            rd_sel = 1'b1;
            #1;
            e = (a < 7) ? 8'(ib + 8'(a) + 8'd3) : 8'h00;
            check($sformatf("ifmap_buf[%0d]", a), {24'b0, rd_data}, {24'b0, e});
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1; my_index = MY; mem_index = MEM; start = 1'b0;
        filter_base = '0; ifmap_base = '0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0; res_valid = 1'b1; res_data = 8'h11;
        rd_sel = 1'b0; rd_addr = '0;

        // Reset state, with res_valid asserted during reset
        @(negedge clk); @(negedge clk);
        check("rst_res_ready", {31'b0, res_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("rst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
        check("rst_rd_data", {24'b0, rd_data}, 32'd0);
        res_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Plain fetch job
        run_job(8'h00, 8'h00, 0, 1'b0);
        check("job1_err", {31'b0, err}, 32'd0);
        check_bufs(8'h00, 8'h00);

        // Backpressure on the first filter request
        @(negedge clk);
        run_job(8'h10, 8'h20, 5, 1'b0);
        check_bufs(8'h10, 8'h20);

        // Mismatched responses in F_WAIT
        @(negedge clk);
        run_job(8'h30, 8'h40, 0, 1'b1);
        check("err_sticky", {31'b0, err}, 32'd1);
        check_bufs(8'h30, 8'h40);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("err_cleared", {31'b0, err}, 32'd0);

        // Result write, with start/res_valid ignored while busy
        d0 = done_cnt;
        res_valid = 1'b1;
        res_data  = 8'h2A;
        #1;
        check("res_ready_idle", {31'b0, res_ready}, 32'd1);
        @(negedge clk);
        res_valid = 1'b0;
        exp_req_q.push_back(pkt(2'b00, MEM, MY, 8'h2A));
        start = 1'b1; res_valid = 1'b1; res_data = 8'h55;
        #1;
        check("res_ready_busy", {31'b0, res_ready}, 32'd0);
        start = 1'b0; res_valid = 1'b0;
        serve_req(2, 1'b0);
        check("res_idle_after", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("res_no_done", done_cnt, d0);

        // start has priority over res_valid; reset after 3rd filter response
        filter_base = 8'h50; ifmap_base = 8'h60;
        start = 1'b1; res_valid = 1'b1; res_data = 8'h77;
        #1;
        check("start_priority", {31'b0, res_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0; res_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_req_q.push_back(pkt(2'b10, MEM, MY, 8'(8'h50 + 8'(k))));
            serve_req(0, 1'b1);
            send_rsp(pkt(2'b10, MEM, MY, 8'(8'h53 + 8'(k))));
        end
        rd_sel = 1'b0; rd_addr = 3'd2;
        #1;
        check("partial_buf", {24'b0, rd_data}, 32'h55);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_req_valid", {31'b0, req_valid}, 32'd0);
        check("midrst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_err", {31'b0, err}, 32'd0);
        check("midrst_buf", {24'b0, rd_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Stale response arriving in IDLE is not consumed
        rsp_valid = 1'b1;
        rsp_data  = pkt(2'b10, MEM, MY, 8'h56);
        #1;
        check("stale_rsp_ready", {31'b0, rsp_ready}, 32'd0);
        @(negedge clk);
        rsp_valid = 1'b0;
        check("stale_err", {31'b0, err}, 32'd0);

        // Refetch from word 0 with address wrap
        run_job(8'hFE, 8'hFC, 0, 1'b0);
        check("wrap_err", {31'b0, err}, 32'd0);
        check_bufs(8'hFE, 8'hFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
